// File: rtl/uart_top.sv
// uart_top: 8N1 UART transmitter and receiver sharing one clock.
//   Each bit lasts CPB = CLK_FREQ / BAUD_RATE clocks.
//   The transmitter and receiver are independent and can run at the same time.
// Ports:
//   clk      - sole clock; all logic runs on the rising edge
//   rst_n    - asynchronous reset, active HIGH (the name is historical)
//   tx_start - transmit request; accepted only when idle
//   tx_data  - byte to send; latched on the accepting edge
//   tx_busy  - high while a TX frame is in progress
//   tx_done  - one-cycle pulse after the stop bit ends
//   tx       - serial output; idles high
//   rx       - serial input; asynchronous to clk; idles high
//   rx_data  - last correctly framed received byte
//   rx_valid - one-cycle pulse when rx_data is updated
module uart_top #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t          tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_baud_q, tx_baud_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shreg_q, tx_shreg_d;
  logic            tx_line_q, tx_line_d;
  logic            tx_busy_q, tx_busy_d;
  logic            tx_done_q, tx_done_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shreg_d = tx_shreg_q;
    tx_line_d  = tx_line_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;
    unique case (tx_state_q)
      S_IDLE: begin
        // A request in the same cycle as the done pulse is dropped, so
        // the earliest new frame starts on the edge after tx_done.
        if (tx_start && !tx_done_q) begin
          tx_shreg_d = tx_data;
          tx_state_d = S_START;
          tx_line_d  = 1'b0;
          tx_busy_d  = 1'b1;
          tx_baud_d  = '0;
          tx_bit_d   = '0;
        end
      end
      S_START: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d  = '0;
          tx_state_d = S_DATA;
          tx_line_d  = tx_shreg_q[0];
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shreg_d = {1'b0, tx_shreg_q[7:1]};
            tx_line_d  = tx_shreg_q[1];
          end
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d  = '0;
          tx_state_d = S_IDLE;
          tx_busy_d  = 1'b0;
          tx_done_d  = 1'b1;
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tx_state_q <= S_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shreg_q <= '0;
      tx_line_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shreg_q <= tx_shreg_d;
      tx_line_q  <= tx_line_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx      = tx_line_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

  // ---------------- receiver ----------------
  // The two synchronizer flops reset high so that reset never looks like
  // a start bit.
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  state_t          rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_baud_q, rx_baud_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shreg_q, rx_shreg_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_ferr_q, rx_ferr_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shreg_d = rx_shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = rx_ferr_q;
    unique case (rx_state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = S_START;
          rx_baud_d  = '0;
        end
      end
      S_START: begin
        // Re-check at mid start bit; a glitch shorter than that is a false start.
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_d = '0;
          if (!rx_sync_q) begin
            rx_state_d = S_DATA;
            rx_bit_d   = '0;
          end else begin
            rx_state_d = S_IDLE;
          end
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = '0;
          rx_shreg_d = {rx_sync_q, rx_shreg_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (rx_ferr_q) begin
          // After a framing error, hold here until the line idles high so the
          // low stop bit is not taken as a new start bit.
          if (rx_sync_q) begin
            rx_ferr_d  = 1'b0;
            rx_state_d = S_IDLE;
          end
        end else if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d = '0;
          if (rx_sync_q) begin
            rx_data_d  = rx_shreg_q;
            rx_valid_d = 1'b1;
            rx_state_d = S_IDLE;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rx_state_q <= S_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shreg_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shreg_q <= rx_shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_uart_top.sv
module tb_uart_top;

  // Small clocks-per-bit keeps the run short: 1.6 MHz / 100 kbaud = 16.
  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int CPB       = 16;
  localparam int HALF      = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy, tx_done, tx;
  logic       rx_line, rx_drv, loopback;
  logic [7:0] rx_data;
  logic       rx_valid;

  int checks = 0;
  int errs   = 0;
  int rx_pulses = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit 0 = start, bits 8:1 = data, bit 9 = stop
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;
  assign rx_line = loopback ? tx : rx_drv;

  uart_top #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx(tx),
    .rx(rx_line), .rx_data(rx_data), .rx_valid(rx_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rx_valid pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL rx_unexpected: got %0h expected no pulse", rx_data);
      end else begin
        chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Sends one byte and checks the serial waveform and handshake timing.
  // With hold_start set, tx_start stays high with altered data throughout.
  task automatic tx_frame(input logic [7:0] d, input logic [9:0] fr, input bit hold_start);
    int n;
    tx_data  = d;
    tx_start = 1'b1;
    step();
    n = 0;
    tx_start = hold_start;
    tx_data  = ~d;
    chk("tx_start_low", {31'd0, tx}, 32'd0);
    chk("tx_busy_set", {31'd0, tx_busy}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      while (n < i * CPB + HALF) begin step(); n++; end
      chk($sformatf("tx_bit%0d_%02h", i, d), {31'd0, tx}, {31'd0, fr[i]});
    end
    while (n < 10 * CPB - 1) begin step(); n++; end
    chk("tx_busy_before_done", {31'd0, tx_busy}, 32'd1);
    chk("tx_done_early", {31'd0, tx_done}, 32'd0);
    step(); n++;
    chk("tx_done_pulse", {31'd0, tx_done}, 32'd1);
    chk("tx_busy_clear", {31'd0, tx_busy}, 32'd0);
    step(); n++;
    tx_start = 1'b0;
    chk("tx_done_one_cycle", {31'd0, tx_done}, 32'd0);
    chk("tx_not_restarted", {31'd0, tx_busy}, 32'd0);
    chk("tx_idle_high", {31'd0, tx}, 32'd1);
  endtask

  task automatic rx_send(input logic [9:0] fr);
    for (int i = 0; i < 10; i++) begin
      rx_drv = fr[i];
      repeat (CPB) step();
    end
  endtask

  task automatic drain(input string name);
    repeat (2 * CPB) step();
    chk(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{data: 8'hA5, frame: 10'b1_10100101_0};
    vecs[1] = '{data: 8'h00, frame: 10'b1_00000000_0};
    vecs[2] = '{data: 8'hFF, frame: 10'b1_11111111_0};
    vecs[3] = '{data: 8'h01, frame: 10'b1_00000001_0};
    vecs[4] = '{data: 8'h80, frame: 10'b1_10000000_0};

    rst_n = 1'b1; tx_start = 1'b0; tx_data = 8'h00; rx_drv = 1'b1; loopback = 1'b1;
    #3;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    repeat (3) step();
    rst_n = 1'b0;
    repeat (2) step();

    // Loopback table, issued back to back.
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].data);
      tx_frame(vecs[i].data, vecs[i].frame, 1'b0);
    end
    drain("loop_drain");
    chk("loop_pulses", rx_pulses, 32'd5);

    // tx_start held high mid-frame with different data is ignored.
    exp_q.push_back(8'hC3);
    tx_frame(8'hC3, 10'b1_11000011_0, 1'b1);
    drain("ignore_drain");
    chk("ignore_rx_data", {24'd0, rx_data}, 32'hC3);

    // False start: a short low glitch produces nothing.
    loopback = 1'b0;
    rx_drv = 1'b0;
    repeat (CPB / 4) step();
    rx_drv = 1'b1;
    repeat (2 * CPB) step();
    chk("false_start_pulses", rx_pulses, 32'd6);
    chk("false_start_hold", {24'd0, rx_data}, 32'hC3);

    // Framing error: stop bit low, then the line stays low a while.
    rx_send(10'b0_00111100_0);
    repeat (2 * CPB) step();
    rx_drv = 1'b1;
    repeat (2 * CPB) step();
    chk("ferr_pulses", rx_pulses, 32'd6);
    chk("ferr_hold", {24'd0, rx_data}, 32'hC3);
    exp_q.push_back(8'h3C);
    rx_send(10'b1_00111100_0);
    drain("after_ferr_drain");
    chk("after_ferr_data", {24'd0, rx_data}, 32'h3C);

    // Reset in the middle of a loopback frame.
    loopback = 1'b1;
    tx_data = 8'h77;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    repeat (3 * CPB) step();
    rst_n = 1'b1;
    #1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
    chk("midrst_done", {31'd0, tx_done}, 32'd0);
    chk("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    step();
    rst_n = 1'b0;
    exp_q.push_back(8'h5A);
    tx_frame(8'h5A, 10'b1_01011010_0, 1'b0);
    drain("post_rst_drain");
    chk("post_rst_data", {24'd0, rx_data}, 32'h5A);
    chk("total_pulses", rx_pulses, 32'd8);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/uart_top.md
UART_TOP -- requirements
Module: uart_top

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003 Derived constant CPB = CLK_FREQ / BAUD_RATE (integer division, 868 at defaults) SHALL define clocks per bit; HALF = CPB / 2.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-high reset (port name kept per codebase; asserted = 1).
REQ-006 tx_start  input  1  request to transmit tx_data; sampled on each rising edge.
REQ-007 tx_data  input  8  byte to transmit; sampled only on the accepting edge.
REQ-008 tx_busy  output  1  high while a frame is in progress.
REQ-009 tx_done  output  1  one-cycle pulse at end of the stop bit.
REQ-010 tx  output  1  serial line out; idle high.
REQ-011 rx  input  1  serial line in; asynchronous to clk; idle high.
REQ-012 rx_data  output  8  last correctly framed received byte.
REQ-013 rx_valid  output  1  one-cycle pulse when rx_data is updated.

Function
REQ-014 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1, each bit exactly CPB clocks.
REQ-015 TX FSM states: IDLE, START, DATA, STOP; a bit counter 0..7 and a baud counter 0..CPB-1.
REQ-016 In IDLE with tx_start=1 at an edge, TX SHALL latch tx_data, enter START, and drive tx=0 and tx_busy=1 from that edge.
REQ-017 START holds CPB clocks, then DATA shifts bits 0..7 at CPB clocks each, then STOP drives tx=1 for CPB clocks.
REQ-018 At the edge ending STOP, TX SHALL return to IDLE, clear tx_busy and assert tx_done for exactly one cycle; a full frame is 10*CPB clocks.
REQ-019 tx_start while tx_busy=1 SHALL be ignored (no queueing); tx_start in the same cycle tx_done pulses is also ignored; the earliest new accept is the following edge.
REQ-020 Changes on tx_data after acceptance SHALL not affect the frame in progress.
REQ-021 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-022 RX FSM states: IDLE, START, DATA, STOP.
REQ-023 In IDLE a synchronized low SHALL enter START; after HALF clocks, if the line is still low enter DATA, else return to IDLE (false start, no output).
REQ-024 In DATA, each bit SHALL be sampled at CPB clocks after the previous sample point (mid-bit) and shifted in LSB first, 8 bits.
REQ-025 In STOP, after CPB clocks the line SHALL be sampled: if 1, rx_data loads the shift register and rx_valid pulses one cycle; if 0 (framing error), the byte is discarded, no pulse, and RX waits for the line to return high before leaving STOP for IDLE.
REQ-026 rx_data SHALL hold its value between valid pulses.
REQ-027 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-028 While rst_n=1, asynchronously: tx=1, tx_busy=0, tx_done=0, rx_data=8'h00, rx_valid=0, both FSMs IDLE, all counters 0, synchronizer flops 1.
REQ-029 Reset asserted mid-frame SHALL abort both frames immediately; after release TX accepts a new tx_start on the first edge and RX waits for a fresh start bit.

Verification
REQ-030 Loopback (rx=tx), defaults, tx_data=8'hA5 with one-cycle tx_start -> tx low for 868 clocks, bits 1,0,1,0,0,1,0,1 then stop; tx_done pulse after 8680 clocks; one rx_valid pulse with rx_data=8'hA5.
REQ-031 Loopback bytes 8'h00, 8'hFF, 8'h01, 8'h80 back-to-back, each issued on the edge after tx_done -> four rx_valid pulses with matching rx_data in order.
REQ-032 tx_start=1 held/pulsed mid-frame with different tx_data -> ignored; the frame carries the original byte; tx_busy stays 1 until tx_done.
REQ-033 rx driven low for CPB/4 clocks then high -> no rx_valid, RX returns to IDLE, rx_data unchanged.
REQ-034 rx frame with stop bit driven 0 -> no rx_valid, rx_data unchanged; next valid frame (8'h3C) received correctly.
REQ-035 rst_n asserted mid-frame -> outputs at reset values immediately; after release, a new 8'h5A transfer completes correctly.
